// File: rtl/nonogram_line_solver.sv
// Streaming nonogram line solver: filters option patterns per line and commits forced cells.
// Optional build macro OPTION_FILTER_EN drops options that contradict already-known cells.
module nonogram_line_solver #(
    parameter int SIZE  = 8,
    parameter int CNT_W = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        started,
    input  logic [2*SIZE*CNT_W-1:0]     old_options_amnt,
    input  logic [SIZE-1:0]             option,
    input  logic                        valid_op,
    output logic                        ready,
    output logic                        out_valid,
    output logic [SIZE-1:0]             out_data,
    output logic                        line_done,
    output logic                        put_back_to_FIFO,
    output logic [SIZE*SIZE-1:0]        assigned,
    output logic [SIZE*SIZE-1:0]        known,
    output logic                        solved,
    output logic                        error
);
    localparam int NL  = 2 * SIZE;
    localparam int IW  = $clog2(NL);
    localparam int CIW = $clog2(SIZE * SIZE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IDX,
        S_OPTS,
        S_COMMIT
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q [NL];
    logic [CNT_W-1:0]       cnt_d [NL];
    logic [IW-1:0]          line_q, line_d;
    logic [SIZE-1:0]        and_q, and_d;
    logic [SIZE-1:0]        or_q, or_d;
    logic [CNT_W-1:0]       surv_q, surv_d;
    logic [CNT_W-1:0]       rem_q, rem_d;
    logic [SIZE*SIZE-1:0]   asg_q, asg_d;
    logic [SIZE*SIZE-1:0]   kn_q, kn_d;
    logic                   solved_q, solved_d;
    logic                   err_q, err_d;

    logic [CIW-1:0]         cidx [SIZE];
    logic [SIZE-1:0]        opt_cells;
    logic [SIZE-1:0]        line_kn;
    logic [IW-1:0]          word_idx;
    logic                   cons;

    assign word_idx = option[IW-1:0];

    // Board position of each cell k of the current line (row or column).
    always_comb begin
        for (int k = 0; k < SIZE; k++) begin
            if (int'(line_q) < SIZE) begin
                cidx[k] = CIW'(int'(line_q) * SIZE + k);
            end else begin
                cidx[k] = CIW'(k * SIZE + int'(line_q) - SIZE);
            end
            opt_cells[k] = option[SIZE-1-k];
            line_kn[k]   = kn_q[cidx[k]];
        end
    end

`ifdef OPTION_FILTER_EN
    logic [SIZE-1:0] line_asg;

    always_comb begin
        for (int k = 0; k < SIZE; k++) begin
            line_asg[k] = asg_q[cidx[k]];
        end
    end

    assign cons = ((opt_cells ^ line_asg) & line_kn) == '0;
`else
    assign cons = 1'b1;
`endif

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        line_d           = line_q;
        and_d            = and_q;
        or_d             = or_q;
        surv_d           = surv_q;
        rem_d            = rem_q;
        asg_d            = asg_q;
        kn_d             = kn_q;
        err_d            = err_q;
        ready            = 1'b0;
        out_valid        = 1'b0;
        out_data         = '0;
        line_done        = 1'b0;
        put_back_to_FIFO = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (started) begin
                    for (int l = 0; l < NL; l++) begin
                        cnt_d[l] = old_options_amnt[l*CNT_W +: CNT_W];
                    end
                    state_d = S_IDX;
                end
            end
            S_IDX: begin
                ready = 1'b1;
                if (valid_op) begin
                    if (option >= SIZE'(NL)) begin
                        err_d = 1'b1;
                    end else if (cnt_q[word_idx] != '0) begin
                        out_valid = 1'b1;
                        out_data  = option;
                        line_d    = word_idx;
                        and_d     = '1;
                        or_d      = '0;
                        surv_d    = '0;
                        rem_d     = cnt_q[word_idx];
                        state_d   = S_OPTS;
                    end
                end
            end
            S_OPTS: begin
                ready = 1'b1;
                if (valid_op) begin
                    if (cons) begin
                        out_valid = 1'b1;
                        out_data  = option;
                        and_d     = and_q & opt_cells;
                        or_d      = or_q | opt_cells;
                        if (surv_q != '1) begin
                            surv_d = surv_q + CNT_W'(1);
                        end
                    end
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_COMMIT;
                    end
                end
            end
            S_COMMIT: begin
                line_done        = 1'b1;
                put_back_to_FIFO = surv_q > CNT_W'(1);
                cnt_d[line_q]    = surv_q;
                if (surv_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    // A cell set in every survivor is 1; clear in every survivor is 0.
                    for (int k = 0; k < SIZE; k++) begin
                        if (!line_kn[k]) begin
                            if (and_q[k]) begin
                                kn_d[cidx[k]]  = 1'b1;
                                asg_d[cidx[k]] = 1'b1;
                            end else if (!or_q[k]) begin
                                kn_d[cidx[k]]  = 1'b1;
                                asg_d[cidx[k]] = 1'b0;
                            end
                        end
                    end
                end
                state_d = (&kn_d) ? S_IDLE : S_IDX;
            end
            default: state_d = S_IDLE;
        endcase

        solved_d = &kn_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '{default: '0};
            line_q   <= '0;
            and_q    <= '0;
            or_q     <= '0;
            surv_q   <= '0;
            rem_q    <= '0;
            asg_q    <= '0;
            kn_q     <= '0;
            solved_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            line_q   <= line_d;
            and_q    <= and_d;
            or_q     <= or_d;
            surv_q   <= surv_d;
            rem_q    <= rem_d;
            asg_q    <= asg_d;
            kn_q     <= kn_d;
            solved_q <= solved_d;
            err_q    <= err_d;
        end
    end

    assign assigned = asg_q;
    assign known    = kn_q;
    assign solved   = solved_q;
    assign error    = err_q;

endmodule

// File: tb/tb_nonogram_line_solver.sv
// Directed bench for nonogram_line_solver (SIZE=3) with an output scoreboard.
module tb_nonogram_line_solver;
    localparam int S  = 3;
    localparam int CW = 7;
    localparam int NL = 2 * S;
    localparam int NC = S * S;

`ifdef OPTION_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             started;
    logic [NL*CW-1:0] old_amnt;
    logic [S-1:0]     option;
    logic             valid_op;
    logic             ready;
    logic             out_valid;
    logic [S-1:0]     out_data;
    logic             line_done;
    logic             put_back;
    logic [NC-1:0]    assigned;
    logic [NC-1:0]    known;
    logic             solved;
    logic             error;

    nonogram_line_solver #(.SIZE(S), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .started          (started),
        .old_options_amnt (old_amnt),
        .option           (option),
        .valid_op         (valid_op),
        .ready            (ready),
        .out_valid        (out_valid),
        .out_data         (out_data),
        .line_done        (line_done),
        .put_back_to_FIFO (put_back),
        .assigned         (assigned),
        .known            (known),
        .solved           (solved),
        .error            (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [S-1:0]  exp_out [$];
    bit            exp_pb [$];
    logic [S-1:0]  opq [$];
    logic [NC-1:0] mk, ma;
    bit            merr;
    int            mcnt [NL];
    int            cfg [NL];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int cidx(input int l, input int k);
        return (l < S) ? l * S + k : k * S + (l - S);
    endfunction

    function automatic bit mcons(input int l, input logic [S-1:0] w);
        bit ok = 1'b1;
        for (int k = 0; k < S; k++) begin
            if (mk[cidx(l, k)] && ma[cidx(l, k)] !== w[S-1-k]) ok = 1'b0;
        end
        return ok || !FILT;
    endfunction

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_out.size() == 0) chk("out_extra", 1, 0);
            else chk("out_data", out_data, exp_out.pop_front());
        end
        if (line_done === 1'b1) begin
            if (exp_pb.size() == 0) chk("done_extra", 1, 0);
            else chk("put_back", put_back, exp_pb.pop_front());
        end
    end

    task automatic model_clear();
        mk = '0;
        ma = '0;
        merr = 1'b0;
        for (int l = 0; l < NL; l++) mcnt[l] = 0;
        exp_out.delete();
        exp_pb.delete();
    endtask

    task automatic chk_zero(input string p);
        chk({p, "_ready"}, ready, 0);
        chk({p, "_outv"}, out_valid, 0);
        chk({p, "_outd"}, out_data, 0);
        chk({p, "_done"}, line_done, 0);
        chk({p, "_pb"}, put_back, 0);
        chk({p, "_asg"}, assigned, 0);
        chk({p, "_known"}, known, 0);
        chk({p, "_solved"}, solved, 0);
        chk({p, "_error"}, error, 0);
    endtask

    task automatic chk_board(input string p);
        chk({p, "_known"}, known, mk);
        chk({p, "_asg"}, assigned, ma);
        chk({p, "_error"}, error, merr);
        chk({p, "_solved"}, solved, &mk);
    endtask

    task automatic rst_dut();
        rst = 1'b1;
        started = 1'b0;
        valid_op = 1'b0;
        option = '0;
        old_amnt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        model_clear();
    endtask

    task automatic start();
        for (int l = 0; l < NL; l++) begin
            old_amnt[l*CW +: CW] = CW'(cfg[l]);
            mcnt[l] = cfg[l];
        end
        started = 1'b1;
        @(posedge clk);
        #1;
        started = 1'b0;
    endtask

    task automatic send(input logic [S-1:0] w);
        bit ok = 1'b0;
        option = w;
        valid_op = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        valid_op = 1'b0;
        chk("send_accept", ok, 1);
    endtask

    task automatic line_run(input int l);
        int n;
        int surv;
        int c;
        logic [S-1:0] a, o, w;
        if (l >= NL) begin
            merr = 1'b1;
            send(S'(l));
            return;
        end
        n = mcnt[l];
        if (n != 0) exp_out.push_back(S'(l));
        send(S'(l));
        if (n == 0) begin
            opq.delete();
            return;
        end
        a = '1;
        o = '0;
        surv = 0;
        for (int i = 0; i < n; i++) begin
            w = (i < opq.size()) ? opq[i] : '0;
            if (mcons(l, w)) begin
                exp_out.push_back(w);
                surv++;
                for (int k = 0; k < S; k++) begin
                    a[k] = a[k] & w[S-1-k];
                    o[k] = o[k] | w[S-1-k];
                end
            end
            send(w);
        end
        exp_pb.push_back(surv > 1);
        // Hold a word through the commit cycle; it must not be taken.
        option = '1;
        valid_op = 1'b1;
        chk("commit_ready", ready, 0);
        @(posedge clk);
        #1;
        valid_op = 1'b0;
        if (surv == 0) begin
            merr = 1'b1;
        end else begin
            for (int k = 0; k < S; k++) begin
                c = cidx(l, k);
                if (!mk[c]) begin
                    if (a[k]) begin
                        mk[c] = 1'b1;
                        ma[c] = 1'b1;
                    end else if (!o[k]) begin
                        mk[c] = 1'b1;
                        ma[c] = 1'b0;
                    end
                end
            end
        end
        mcnt[l] = surv;
        opq.delete();
        chk_board("commit");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [S-1:0] w;
        rst_dut();

        option = 3'b101;
        valid_op = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", ready, 0);
        chk("idle_outv", out_valid, 0);
        valid_op = 1'b0;

        cfg = '{2, 3, 1, 1, 2, 3};
        start();
        opq = '{3'b110, 3'b011};
        line_run(0);
        opq = '{3'b100, 3'b010, 3'b001};
        line_run(1);
        opq = '{3'b101};
        line_run(2);
        chk("rows_asg", assigned, 9'h142);
        chk("rows_known", known, 9'h1C2);

        opq = '{3'b101};
        line_run(3);
        opq = '{3'b110, 3'b011};
        line_run(4);
        opq = '{3'b100, 3'b010, 3'b001};
        line_run(5);
        chk("fin_asg", assigned, 9'h153);
        chk("fin_known", known, FILT ? 9'h1FF : 9'h1DB);
        chk("fin_solved", solved, FILT);
        chk("fin_error", error, 0);
        chk("fin_ready", ready, FILT ? 1'b0 : 1'b1);

        rst_dut();
        cfg = '{0, 2, 1, 127, 1, 3};
        start();
        line_run(0);
        chk("skip_ready", ready, 1);
        opq = '{3'b100, 3'b100};
        line_run(1);
        opq.push_back(3'b111);
        for (int i = 1; i < 127; i++) opq.push_back(S'($urandom_range(0, 7)));
        line_run(3);
        opq = '{3'b010};
        line_run(4);
        chk("conflict_error", error, FILT);

        line_run(6);
        chk("range_error", error, 1);
        chk("range_ready", ready, 1);

        exp_out.push_back(S'(5));
        send(S'(5));
        w = 3'b001;
        if (mcons(5, w)) exp_out.push_back(w);
        send(w);
        chk("opts_ready", ready, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("midrst");
        rst = 1'b0;
        model_clear();
        valid_op = 1'b1;
        @(posedge clk);
        #1;
        chk("post_ready", ready, 0);
        chk("post_outv", out_valid, 0);
        valid_op = 1'b0;

        chk("out_q_left", exp_out.size(), 0);
        chk("pb_q_left", exp_pb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nonogram_line_solver.md
NONOGRAM_LINE_SOLVER -- requirements
Module: nonogram_line_solver

Interface
REQ-001 SHALL have parameter SIZE, default 8, board edge length; legal range 3..16.
REQ-002 SHALL have parameter CNT_W, default 7, width of each per-line option count.
REQ-003 SHALL have port clk, input, 1, the sole clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port started, input, 1, one-cycle pulse in IDLE that loads counts and begins solving.
REQ-006 SHALL have port old_options_amnt, input, 2*SIZE*CNT_W, initial counts; line l at [l*CNT_W +: CNT_W]; lines 0..SIZE-1 are rows, SIZE..2*SIZE-1 are columns.
REQ-007 SHALL have port option, input, SIZE, stream word: a line index (zero-extended) or an option pattern.
REQ-008 SHALL have port valid_op, input, 1, option word valid.
REQ-009 SHALL have port ready, output, 1, word accepted when valid_op && ready.
REQ-010 SHALL have port out_valid / out_data, output, 1 / SIZE, re-emitted header and surviving options.
REQ-011 SHALL have port line_done, output, 1, one-cycle pulse at commit of a line.
REQ-012 SHALL have port put_back_to_FIFO, output, 1, valid with line_done; 1 = line still has >1 survivor.
REQ-013 SHALL have port assigned / known, output, SIZE*SIZE each, cell (r,c) at bit r*SIZE+c.
REQ-014 SHALL have port solved, output, 1, all known bits set.
REQ-015 SHALL have port error, output, 1, sticky contradiction flag.

Function
REQ-016 SHALL implement states IDLE, IDX, OPTS, COMMIT; ready=1 only in IDX and OPTS.
REQ-017 IDLE: started=1 SHALL latch old_options_amnt into the count memory and go to IDX next cycle.
REQ-018 IDX: accepted word is the line index L; an L >= 2*SIZE SHALL set error and stay in IDX.
REQ-019 IDX: if count[L]==0 the line is skipped (stay in IDX, no commit, no output); else the index is emitted on out_data with out_valid in the same cycle, accumulators init (AND=all ones, OR=0, survivors=0), go to OPTS.
REQ-020 Pattern bit option[SIZE-1-k] SHALL map to cell k of the line (row L: cell (L,k); column L-SIZE: cell (k,L-SIZE)).
REQ-021 OPTS: each accepted option is consistent iff it matches assigned on every known cell of line L; consistent options are ANDed/ORed into the accumulators, survivors+1, and emitted on out_data the same cycle.
REQ-022 OPTS SHALL consume exactly count[L] options, then go to COMMIT (one cycle, ready=0).
REQ-023 COMMIT: for each cell, AND bit 1 -> known=1, assigned=1; OR bit 0 -> known=1, assigned=0; already-known cells unchanged.
REQ-024 COMMIT: count[L] SHALL become survivors; line_done=1; put_back_to_FIFO = (survivors>1); survivors==0 SHALL set error and leave the board unchanged; next state IDX.
REQ-025 solved SHALL be registered, rising the cycle after the commit that sets the last known bit; after solved the FSM SHALL return to IDLE.
REQ-026 Counters SHALL be CNT_W wide and never wrap; a count of 2**CNT_W-1 is legal.
REQ-027 valid_op while ready=0 SHALL be ignored (word not consumed).

Reset
REQ-028 rst=1 SHALL force IDLE and clear counts, accumulators, assigned, known, and every output to 0, overriding any in-flight line.
REQ-029 error SHALL clear only on rst.

Configuration
REQ-030 With OPTION_FILTER_EN defined, consistency filtering per REQ-021 is active.
REQ-031 Without OPTION_FILTER_EN, every option is treated as consistent (survivors == count[L]); all else identical.

Verification
REQ-032 SIZE=3, counts {2,3,1,1,2,3}; stream 0,110,011,1,100,010,001,2,101 -> after row 2 commit: assigned row0=010,row2=101; known row0=010,row2=111; put_back 1,1,0.
REQ-033 Continue 3,101,4,110,011,5,100,010,001 -> col1 survivor 110, col2 survivor 001; board 110/010/101 fully known; solved=1; error=0.
REQ-034 Same stream without OPTION_FILTER_EN -> col1 put_back=1, col2 put_back=1, solved=0.
REQ-035 Line whose options all conflict with known cells -> survivors 0, error=1, board unchanged.
REQ-036 rst asserted mid-OPTS -> next cycle IDLE, all outputs 0; valid_op held during COMMIT -> word not consumed.
